// File: rtl/program_loader.sv
// Packs a received byte stream (MSB first) into 32-bit instructions and writes
// them to consecutive instruction-RAM words until HALT_WORD or the RAM is full.
module program_loader #(
    parameter int                 RAM_WIDTH  = 32,
    parameter int                 RAM_DEPTH  = 2048,
    parameter int                 BYTE_WIDTH = 8,
    parameter logic [RAM_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BYTE_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_done,
    output logic [RAM_WIDTH-1:0]  o_addra,
    output logic [RAM_WIDTH-1:0]  o_dina,
    output logic                  o_wea,
    output logic                  o_ena,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [RAM_WIDTH-1:0]  o_word_count
);

    localparam logic [RAM_WIDTH-1:0] LAST_INDEX = RAM_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t               state;
    logic [1:0]           byte_cnt;
    logic [RAM_WIDTH-1:0] pack;
    logic [RAM_WIDTH-1:0] word;
    logic [RAM_WIDTH-1:0] pack_next;

    // New byte enters at the bottom, so the first byte of a word ends up in the MSBs.
    assign pack_next = {pack[RAM_WIDTH-BYTE_WIDTH-1:0], i_rx_data};

    // o_word_count doubles as the word index: both clear together and advance on every write.
    // NOTE: all state here is sequential, so every assignment is non-blocking; mixing
    // blocking writes into a clocked block creates simulation/synthesis ordering mismatches.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            pack         <= '0;
            word         <= '0;
            o_addra      <= '0;
            o_dina       <= '0;
            o_wea        <= 1'b0;
            o_ena        <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_wea <= 1'b0;
            o_ena <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state        <= RECV;
                        byte_cnt     <= '0;
                        o_word_count <= '0;
                        o_overflow   <= 1'b0;
                        o_busy       <= 1'b1;
                    end
                end
                RECV: begin
                    if (i_rx_done) begin
                        pack <= pack_next;
                        if (byte_cnt == 2'd3) begin
                            word     <= pack_next;
                            byte_cnt <= '0;
                            state    <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    o_wea        <= 1'b1;
                    o_ena        <= 1'b1;
                    o_addra      <= o_word_count;
                    o_dina       <= word;
                    o_word_count <= o_word_count + 1'b1;
                    // A strobe arriving here is the first byte of the next word.
                    if (i_rx_done) begin
                        pack     <= pack_next;
                        byte_cnt <= 2'd1;
                    end
                    if (word == HALT_WORD) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else if (o_word_count == LAST_INDEX) begin
                        state      <= DONE;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        o_overflow <= 1'b1;
                    end else begin
                        state <= RECV;
                    end
                end
                DONE: begin
                    if (i_start) begin
                        state        <= RECV;
                        byte_cnt     <= '0;
                        o_word_count <= '0;
                        o_overflow   <= 1'b0;
                        o_done       <= 1'b0;
                        o_busy       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
